// File: rtl/player_mask_pkg.sv
// Shared state encoding, default screen/cell geometry and packed-mask bit indexing
// for the player bit-mask capture block.
package player_mask_pkg;

    localparam int unsigned SCREEN_WIDTH       = 1280;
    localparam int unsigned SCREEN_HEIGHT      = 720;
    localparam int unsigned DOWN_SAMPLE_FACTOR = 16;
    localparam int unsigned BIT_MASK_WIDTH     = SCREEN_WIDTH / DOWN_SAMPLE_FACTOR;
    localparam int unsigned BIT_MASK_HEIGHT    = SCREEN_HEIGHT / DOWN_SAMPLE_FACTOR;
    localparam int unsigned BIT_MASK_SIZE      = BIT_MASK_WIDTH * BIT_MASK_HEIGHT;
    localparam int unsigned NUM_SLOTS          = 10;
    localparam int unsigned THRESHOLD          = 128;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Row-major packing: bit index = row * width + col.
    function automatic int unsigned mask_bit_idx(input int unsigned row,
                                                 input int unsigned col,
                                                 input int unsigned width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/player_bit_mask_capture_if.sv
// Pixel stream, capture request and mask-RAM write port of the player bit-mask capture block.
interface player_bit_mask_capture_if
    import player_mask_pkg::*;
#(
    parameter int unsigned SLOT_W = $clog2(NUM_SLOTS),
    parameter int unsigned MASK_W = BIT_MASK_SIZE
) ();

    logic [HCOUNT_W-1:0] hcount_in;
    logic [VCOUNT_W-1:0] vcount_in;
    logic                pixel_valid_in;
    logic                mask_pixel_in;
    logic                capture_in;
    logic [SLOT_W-1:0]   slot_idx_in;
    logic                busy_out;
    logic                done_out;
    logic                wea_out;
    logic [SLOT_W-1:0]   addra_out;
    logic [MASK_W-1:0]   dina_out;

    modport master (
        output hcount_in, vcount_in, pixel_valid_in, mask_pixel_in, capture_in, slot_idx_in,
        input  busy_out, done_out, wea_out, addra_out, dina_out
    );

    modport slave (
        input  hcount_in, vcount_in, pixel_valid_in, mask_pixel_in, capture_in, slot_idx_in,
        output busy_out, done_out, wea_out, addra_out, dina_out
    );

endinterface

// File: rtl/player_bit_mask_capture_stripe_accumulator.sv
// Per-column set-pixel counters for one DOWN_SAMPLE_FACTOR-line stripe, with the
// threshold compare taken on the post-increment counts.
module stripe_accumulator
    import player_mask_pkg::*;
#(
    parameter int unsigned NUM_COLS = BIT_MASK_WIDTH,
    parameter int unsigned CELL     = DOWN_SAMPLE_FACTOR,
    parameter int unsigned THRESH   = THRESHOLD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                inc,
    input  logic [HCOUNT_W-1:0] col,
    input  logic                commit,
    output logic [NUM_COLS-1:0] row_c
);

    localparam int unsigned CNT_MAX = CELL * CELL;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    logic [CNT_W-1:0] cnt_q    [NUM_COLS];
    logic [CNT_W-1:0] cnt_post [NUM_COLS];

    // Restart drops held counts before the current pixel contributes.
    always_comb begin
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            cnt_post[i] = restart ? '0 : cnt_q[i];
            if (inc && (col == HCOUNT_W'(i)) && (cnt_post[i] != CNT_W'(CNT_MAX))) begin
                cnt_post[i] = cnt_post[i] + CNT_W'(1);
            end
            row_c[i] = (cnt_post[i] >= CNT_W'(THRESH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                cnt_q[i] <= commit ? '0 : cnt_post[i];
            end
        end
    end

endmodule

// File: rtl/player_bit_mask_capture.sv
// Captures one frame of the 1-bit player stream into a down-sampled mask and writes it
// to one mask-RAM slot. PLAYER_MASK_DILATE_EN widens each committed row bit horizontally.
module player_bit_mask_capture
    import player_mask_pkg::*;
#(
    parameter int unsigned SCR_W   = SCREEN_WIDTH,
    parameter int unsigned SCR_H   = SCREEN_HEIGHT,
    parameter int unsigned DSF     = DOWN_SAMPLE_FACTOR,
    parameter int unsigned N_SLOTS = NUM_SLOTS,
    parameter int unsigned THRESH  = THRESHOLD
) (
    input logic                      clk_in,
    input logic                      rst_n_in,
    player_bit_mask_capture_if.slave bus
);

    localparam int unsigned BM_W     = SCR_W / DSF;
    localparam int unsigned BM_H     = SCR_H / DSF;
    localparam int unsigned BM_SIZE  = BM_W * BM_H;
    localparam int unsigned SLOT_W   = $clog2(N_SLOTS);
    localparam int unsigned DSF_LOG2 = $clog2(DSF);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SLOT_W-1:0]   addra_q, addra_d;
    logic [BM_SIZE-1:0]  mask_q, mask_d;
    logic [BM_SIZE-1:0]  dina_q, dina_d;
    logic                busy_q, busy_d;
    logic                wea_q, wea_d;
    logic                done_q, done_d;

    logic                pix_in_range;
    logic                at_origin;
    logic                stripe_end;
    logic                last_row;
    logic                acc_restart;
    logic                acc_inc;
    logic                acc_commit;
    logic [HCOUNT_W-1:0] cell_col;
    logic [VCOUNT_W-1:0] cell_row;
    logic [BM_W-1:0]     row_raw;
    logic [BM_W-1:0]     row_eff;

    // Pixel position decode against the active area and the cell grid.
    always_comb begin
        pix_in_range = bus.pixel_valid_in
                    && (bus.hcount_in < HCOUNT_W'(SCR_W))
                    && (bus.vcount_in < VCOUNT_W'(SCR_H));
        at_origin    = bus.pixel_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
        stripe_end   = pix_in_range
                    && (bus.hcount_in == HCOUNT_W'(SCR_W - 1))
                    && (bus.vcount_in[DSF_LOG2-1:0] == '1);
        cell_col     = bus.hcount_in >> DSF_LOG2;
        cell_row     = bus.vcount_in >> DSF_LOG2;
        last_row     = (cell_row == VCOUNT_W'(BM_H - 1));
    end

    // A valid origin pixel (re)starts the frame whether armed or already accumulating.
    always_comb begin
        acc_restart = at_origin && ((state_q == ARMED) || (state_q == ACCUM));
        acc_inc     = bus.mask_pixel_in && pix_in_range && ((state_q == ACCUM) || acc_restart);
        acc_commit  = stripe_end && (state_q == ACCUM);
    end

    stripe_accumulator #(
        .NUM_COLS (BM_W),
        .CELL     (DSF),
        .THRESH   (THRESH)
    ) u_stripe_acc (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .restart (acc_restart),
        .inc     (acc_inc),
        .col     (cell_col),
        .commit  (acc_commit),
        .row_c   (row_raw)
    );

`ifdef PLAYER_MASK_DILATE_EN
    assign row_eff = row_raw | (row_raw << 1) | (row_raw >> 1);
`else
    assign row_eff = row_raw;
`endif

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            slot_q  <= '0;
            mask_q  <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            busy_q  <= 1'b0;
            wea_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            mask_q  <= mask_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            busy_q  <= busy_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.capture_in) state_d = ARMED;
            ARMED:   if (at_origin) state_d = ACCUM;
            ACCUM:   if (acc_commit && last_row) state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so WRITE and DONE align with wea/done.
    always_comb begin
        slot_d  = slot_q;
        mask_d  = mask_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        busy_d  = (state_d != IDLE);
        wea_d   = (state_d == WRITE);
        done_d  = (state_d == DONE);

        if ((state_q == IDLE) && bus.capture_in) begin
            slot_d = bus.slot_idx_in;
        end
        if (acc_restart) begin
            mask_d = '0;
        end
        if (acc_commit) begin
            mask_d[mask_bit_idx(32'(cell_row), 0, BM_W) +: BM_W] = row_eff;
        end
        // Snapshot includes the final row committed this cycle.
        if (wea_d) begin
            addra_d = slot_q;
            dina_d  = mask_d;
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.wea_out   = wea_q;
    assign bus.done_out  = done_q;
    assign bus.addra_out = addra_q;
    assign bus.dina_out  = dina_q;

endmodule

// File: tb/tb_player_bit_mask_capture.sv
// Scoreboard bench for player_bit_mask_capture on a 64x48 screen (4x3 cells of 16x16).
// Build both RTL and bench with PLAYER_MASK_DILATE_EN to check the dilated variant.
module tb_player_bit_mask_capture;

    localparam int unsigned SCR_W   = 64;
    localparam int unsigned SCR_H   = 48;
    localparam int unsigned DSF     = 16;
    localparam int unsigned N_SLOTS = 10;
    localparam int unsigned THRESH  = 128;
    localparam int unsigned BM_W    = SCR_W / DSF;
    localparam int unsigned BM_H    = SCR_H / DSF;
    localparam int unsigned BM_SIZE = BM_W * BM_H;
    localparam int unsigned SLOT_W  = $clog2(N_SLOTS);

    typedef struct {
        logic [SLOT_W-1:0]  slot;
        logic [BM_SIZE-1:0] mask;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_bit_mask_capture_if #(.SLOT_W(SLOT_W), .MASK_W(BM_SIZE)) bus ();

    player_bit_mask_capture #(
        .SCR_W   (SCR_W),
        .SCR_H   (SCR_H),
        .DSF     (DSF),
        .N_SLOTS (N_SLOTS),
        .THRESH  (THRESH)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int                 n_checks  = 0;
    int                 n_fail    = 0;
    int                 wea_count = 0;
    int                 n_pushed  = 0;
    exp_t               sb_q[$];
    int unsigned        cnt_m [BM_H][BM_W];
    int unsigned        dens  [BM_H][BM_W];
    int                 exp_slot  = 0;
    logic [BM_SIZE-1:0] last_mask = '0;
    logic               prev_wea  = 1'b0;
    logic               prev_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic bit pat(input int mode, input int x, input int y);
        int li;
        li = (y % DSF) * DSF + (x % DSF);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (x / DSF == 1) && (y / DSF == 1) && (li < 128);
            3: return (x / DSF == 1) && (y / DSF == 1) && (li < 127);
            4: return (x / DSF == BM_W - 1) && (y / DSF == BM_H - 1) && (li >= 128);
            5: return $urandom_range(0, 255) < dens[y / DSF][x / DSF];
            6: return (x / DSF == 0) && (y / DSF == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BM_SIZE-1:0] model_mask();
        logic [BM_SIZE-1:0] raw;
        logic [BM_SIZE-1:0] res;
        raw = '0;
        for (int r = 0; r < int'(BM_H); r++)
            for (int c = 0; c < int'(BM_W); c++)
                raw[r * BM_W + c] = (cnt_m[r][c] >= THRESH);
        res = raw;
`ifdef PLAYER_MASK_DILATE_EN
        for (int r = 0; r < int'(BM_H); r++)
            for (int c = 0; c < int'(BM_W); c++) begin
                if (c > 0 && raw[r * BM_W + c - 1]) res[r * BM_W + c] = 1'b1;
                if (c + 1 < int'(BM_W) && raw[r * BM_W + c + 1]) res[r * BM_W + c] = 1'b1;
            end
`endif
        return res;
    endfunction

    task automatic drive_pixel(input bit v, input int x, input int y, input bit b,
                               input bit cap, input int cap_slot);
        @(posedge clk);
        #1;
        bus.pixel_valid_in = v;
        bus.hcount_in      = 11'(x);
        bus.vcount_in      = 10'(y);
        bus.mask_pixel_in  = b;
        bus.capture_in     = cap;
        bus.slot_idx_in    = SLOT_W'(cap_slot);
        if (v && x == 0 && y == 0)
            foreach (cnt_m[r, c]) cnt_m[r][c] = 0;
        if (v && b && x < int'(SCR_W) && y < int'(SCR_H) && cnt_m[y / DSF][x / DSF] < DSF * DSF)
            cnt_m[y / DSF][x / DSF]++;
    endtask

    task automatic capture(input int s);
        @(posedge clk);
        #1;
        bus.pixel_valid_in = 1'b0;
        bus.capture_in     = 1'b1;
        bus.slot_idx_in    = SLOT_W'(s);
        exp_slot           = s;
        @(posedge clk);
        #1;
        bus.capture_in = 1'b0;
        check("armed_busy", 64'(bus.busy_out), 64'(1));
    endtask

    // Raster-scans n_lines lines with stalls and blanking; cap_line injects a stray capture.
    task automatic drive_frame(input int mode, input int n_lines, input int cap_line);
        exp_t e;
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < int'(SCR_W); x++) begin
                if (x == 7 && (y % 5) == 0) drive_pixel(1'b0, 0, 0, 1'b1, 1'b0, 0);
                drive_pixel(1'b1, x, y, pat(mode, x, y), (y == cap_line) && (x == 3), 7);
                if (y == int'(SCR_H) - 1 && x == int'(SCR_W) - 1) begin
                    e.slot = SLOT_W'(exp_slot);
                    e.mask = model_mask();
                    sb_q.push_back(e);
                    last_mask = e.mask;
                    n_pushed++;
                    @(posedge clk);
                    #1;
                    bus.pixel_valid_in = 1'b0;
                    check("wea_latency", 64'(bus.wea_out), 64'(1));
                    return;
                end
            end
            drive_pixel(1'b1, SCR_W, y, 1'b1, 1'b0, 0);
            drive_pixel(1'b1, 5, SCR_H + 1, 1'b1, 1'b0, 0);
            drive_pixel(1'b1, SCR_W + 3, y, 1'b1, 1'b0, 0);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy_out && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", 64'(bus.busy_out), 64'(0));
        check("dina_hold", 64'(bus.dina_out), 64'(last_mask));
    endtask

    task automatic run_frame(input int s, input int mode);
        capture(s);
        drive_frame(mode, SCR_H, -1);
        wait_idle();
    endtask

    // Write-port monitor: pops the scoreboard on every wea and checks done/busy sequencing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_wea  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus.wea_out) begin
                wea_count++;
                check("wea_single_cycle", 64'(prev_wea), 64'(0));
                check("busy_in_write", 64'(bus.busy_out), 64'(1));
                if (sb_q.size() == 0) begin
                    check("wea_unexpected", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("addra", 64'(bus.addra_out), 64'(e.slot));
                    check("dina", 64'(bus.dina_out), 64'(e.mask));
                end
            end
            if (prev_wea || bus.done_out) check("done_after_wea", 64'(bus.done_out), 64'(prev_wea));
            if (prev_done) check("busy_released", 64'(bus.busy_out), 64'(0));
            prev_wea  = bus.wea_out;
            prev_done = bus.done_out;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          w0;
        int unsigned picks [8];
        picks = '{0, 64, 127, 128, 129, 192, 255, 256};
        bus.pixel_valid_in = 1'b0;
        bus.hcount_in      = '0;
        bus.vcount_in      = '0;
        bus.mask_pixel_in  = 1'b0;
        bus.capture_in     = 1'b0;
        bus.slot_idx_in    = '0;
        foreach (cnt_m[r, c]) cnt_m[r][c] = 0;
        foreach (dens[r, c]) dens[r][c] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy_out), 64'(0));
        check("rst_done", 64'(bus.done_out), 64'(0));
        check("rst_wea", 64'(bus.wea_out), 64'(0));
        check("rst_addra", 64'(bus.addra_out), 64'(0));
        check("rst_dina", 64'(bus.dina_out), 64'(0));
        rst_n = 1'b1;

        run_frame(3, 1);
        run_frame(4, 2);
        run_frame(0, 3);
        run_frame(9, 4);
        run_frame(2, 6);

        capture(6);
        drive_frame(1, SCR_H, 10);
        wait_idle();

        capture(8);
        drive_frame(1, 20, -1);
        drive_frame(0, SCR_H, -1);
        wait_idle();

        capture(5);
        drive_frame(1, 30, -1);
        w0 = wea_count;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy", 64'(bus.busy_out), 64'(0));
        check("abort_wea", 64'(bus.wea_out), 64'(0));
        check("abort_dina", 64'(bus.dina_out), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", 64'(wea_count), 64'(w0));
        rst_n = 1'b1;
        last_mask = '0;
        run_frame(1, 0);

        for (int k = 0; k < 2; k++) begin
            foreach (dens[r, c]) dens[r][c] = picks[$urandom_range(0, 7)];
            run_frame(int'($urandom_range(0, N_SLOTS - 1)), 5);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        check("write_count", 64'(wea_count), 64'(n_pushed));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
